// File: rtl/add64_stim_gen.sv
// ---------------------------------------------------------------------------
// add64_stim_gen
//
// Stimulus sequencer for the 64-bit adder datapath. After a start request it
// presents a fixed set of eight directed corner vectors, followed by N_RANDOM
// pseudo-random vectors taken from a 64-bit Galois LFSR, and then reports
// completion. Vectors are offered under a valid/ready handshake.
//
// Parameters
//   N_RANDOM  number of random vectors after the directed set (0..65527)
//   SEED      LFSR load value; 0 is replaced by 64'h1
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset
//   start      in   begin a sequence (honoured only in IDLE or DONE)
//   out_valid  out  a / b / c_in / vec_idx carry a valid vector
//   out_ready  in   consumer accepts the vector this cycle
//   a, b       out  64-bit operands
//   c_in       out  carry-in
//   vec_idx    out  index of the presented vector
//   busy       out  sequence in progress (DIRECTED or RANDOM)
//   done       out  sequence complete (DONE)
// ---------------------------------------------------------------------------
module add64_stim_gen #(
    parameter int unsigned N_RANDOM = 16,
    parameter logic [63:0] SEED     = 64'hACE1_2468_1357_BDF0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] a,
    output logic [63:0] b,
    output logic        c_in,
    output logic [15:0] vec_idx,
    output logic        busy,
    output logic        done
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DIRECTED = 2'd1;
    localparam logic [1:0] S_RANDOM   = 2'd2;
    localparam logic [1:0] S_DONE     = 2'd3;

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [63:0] SEED_EFF  = (SEED == 64'h0) ? 64'h1 : SEED;
    localparam logic [63:0] LFSR_MASK = 64'hD800_0000_0000_0000;
    localparam logic [63:0] B_XOR     = 64'h5555_5555_5555_5555;

    localparam logic [15:0] LAST_DIR_IDX = 16'd7;
    localparam logic [15:0] LAST_IDX     = 16'(7 + N_RANDOM);
    localparam bit          HAS_RANDOM   = (N_RANDOM != 0);

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic        c_in;
    } payload_t;

    // -----------------------------------------------------------------------
    // Vector sources
    // -----------------------------------------------------------------------
    function automatic payload_t directed_vec(input logic [2:0] idx);
        payload_t p;
        p = '0;
        case (idx)
            3'd0: p = '{a: '1, b: '1, c_in: 1'b1};
            3'd1: p = '{a: '1, b: 64'hFFFF_FFFF_FFFF_FFFE, c_in: 1'b1};
            3'd2: p = '{a: '1, b: 64'hFFFF_FFFF_FFFF_FFFE, c_in: 1'b0};
            3'd3: p = '{a: 64'h12, b: 64'h11, c_in: 1'b1};
            3'd4: p = '{a: 64'h12, b: 64'h11, c_in: 1'b0};
            3'd5: p = '{a: 64'h12_4552, b: 64'h4_7264, c_in: 1'b1};
            3'd6: p = '{a: 64'h12_4552, b: 64'h4_7264, c_in: 1'b0};
            default: p = '0;
        endcase
        return p;
    endfunction

    // Right-shifting Galois step: the bit shifted out selects the tap mask.
    function automatic logic [63:0] lfsr_step(input logic [63:0] l);
        return (l >> 1) ^ (l[0] ? LFSR_MASK : 64'h0);
    endfunction

    function automatic payload_t random_vec(input logic [63:0] l);
        payload_t p;
        p.a    = l;
        p.b    = {l[31:0], l[63:32]} ^ B_XOR;
        p.c_in = l[63] ^ l[0];
        return p;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]  state_q, state_d;
    logic [63:0] lfsr_q,  lfsr_d;
    payload_t    pay_q,   pay_d;
    logic        valid_q, valid_d;
    logic [15:0] idx_q,   idx_d;

    logic        xfer;
    logic [63:0] lfsr_next;

    assign xfer      = valid_q & out_ready;
    assign lfsr_next = lfsr_step(lfsr_q);

    // -----------------------------------------------------------------------
    // Next-state logic
    //
    // The payload register always holds the vector for idx_q. In RANDOM it
    // is f(lfsr_q): on a transfer the LFSR advances and the payload is
    // loaded from the advanced value, so a and L stay in lock-step. The
    // first random vector comes from the un-advanced seed.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        pay_d   = pay_q;
        valid_d = valid_q;
        idx_d   = idx_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_DIRECTED;
                    lfsr_d  = SEED_EFF;
                    pay_d   = directed_vec(3'd0);
                    valid_d = 1'b1;
                    idx_d   = '0;
                end
            end

            S_DIRECTED: begin
                if (xfer) begin
                    idx_d = idx_q + 16'd1;
                    if (idx_q == LAST_DIR_IDX) begin
                        if (HAS_RANDOM) begin
                            state_d = S_RANDOM;
                            pay_d   = random_vec(lfsr_q);
                        end else begin
                            state_d = S_DONE;
                            valid_d = 1'b0;
                        end
                    end else begin
                        pay_d = directed_vec(idx_q[2:0] + 3'd1);
                    end
                end
            end

            S_RANDOM: begin
                if (xfer) begin
                    lfsr_d = lfsr_next;
                    idx_d  = idx_q + 16'd1;
                    if (idx_q == LAST_IDX) begin
                        // Payload keeps the last presented vector.
                        state_d = S_DONE;
                        valid_d = 1'b0;
                    end else begin
                        pay_d = random_vec(lfsr_next);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEED_EFF;
            pay_q   <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            pay_q   <= pay_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs (register-driven only; out_ready never reaches them directly)
    // -----------------------------------------------------------------------
    assign out_valid = valid_q;
    assign a         = pay_q.a;
    assign b         = pay_q.b;
    assign c_in      = pay_q.c_in;
    assign vec_idx   = idx_q;
    assign busy      = (state_q == S_DIRECTED) || (state_q == S_RANDOM);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_add64_stim_gen.sv
// ---------------------------------------------------------------------------
// Bench for add64_stim_gen. Three instances cover N_RANDOM=0, N_RANDOM=4
// with the default seed, and N_RANDOM=2 with a zero seed. Expected vectors
// are pushed to a scoreboard queue on each start and popped on each
// observed transfer; stalls are checked for payload stability.
// ---------------------------------------------------------------------------
module tb_add64_stim_gen;

    localparam logic [63:0] SEED_DEF = 64'hACE1_2468_1357_BDF0;
    localparam logic [63:0] SEED_STEP1 = 64'h5670_9234_09AB_DEF8;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] sum;
        logic        cout;
    } dir_t;

    typedef struct {
        int          dut;
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [15:0] idx;
    } exp_t;

    logic        clk;
    logic [2:0]  rst_v, start_v, ready_v, valid_v, cin_v, busy_v, done_v;
    logic [63:0] a_v [3];
    logic [63:0] b_v [3];
    logic [15:0] idx_v [3];

    dir_t        dtab [8];
    exp_t        sbq [$];

    int          n_tests = 0;
    int          n_fail  = 0;

    logic        pv [3], pr [3], prst [3];
    logic [63:0] pa [3], pb [3];
    logic        pc [3];
    logic [15:0] pi [3];
    logic [63:0] first_rand [3], second_rand [3];

    add64_stim_gen #(.N_RANDOM(0)) u_dut0 (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .out_valid(valid_v[0]),
        .out_ready(ready_v[0]), .a(a_v[0]), .b(b_v[0]), .c_in(cin_v[0]),
        .vec_idx(idx_v[0]), .busy(busy_v[0]), .done(done_v[0]));

    add64_stim_gen #(.N_RANDOM(4)) u_dut1 (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .out_valid(valid_v[1]),
        .out_ready(ready_v[1]), .a(a_v[1]), .b(b_v[1]), .c_in(cin_v[1]),
        .vec_idx(idx_v[1]), .busy(busy_v[1]), .done(done_v[1]));

    add64_stim_gen #(.N_RANDOM(2), .SEED(64'h0)) u_dut2 (
        .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .out_valid(valid_v[2]),
        .out_ready(ready_v[2]), .a(a_v[2]), .b(b_v[2]), .c_in(cin_v[2]),
        .vec_idx(idx_v[2]), .busy(busy_v[2]), .done(done_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] gstep(input logic [63:0] l);
        logic [63:0] r;
        r = {1'b0, l[63:1]};
        if (l[0]) r = r ^ 64'hD800_0000_0000_0000;
        return r;
    endfunction

    // Expected sequence for one start of instance d.
    task automatic push_seq(input int d, input int nrand, input logic [63:0] seed);
        exp_t e;
        logic [63:0] l;
        l = (seed == 64'h0) ? 64'h1 : seed;
        for (int k = 0; k < 8; k++) begin
            e.dut = d; e.a = dtab[k].a; e.b = dtab[k].b; e.cin = dtab[k].cin;
            e.idx = 16'(k);
            sbq.push_back(e);
        end
        for (int k = 0; k < nrand; k++) begin
            e.dut = d; e.a = l;
            e.b = {l[31:0], l[63:32]} ^ 64'h5555_5555_5555_5555;
            e.cin = l[63] ^ l[0];
            e.idx = 16'(8 + k);
            sbq.push_back(e);
            l = gstep(l);
        end
    endtask

    // One clock: monitor at the falling edge, return 1 time unit after the
    // rising edge so callers drive inputs away from the sampling edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            if (pv[d] && !pr[d] && !prst[d]) begin
                chk($sformatf("d%0d_stall_valid", d), 64'(valid_v[d]), 64'h1);
                chk($sformatf("d%0d_stall_a", d), a_v[d], pa[d]);
                chk($sformatf("d%0d_stall_b", d), b_v[d], pb[d]);
                chk($sformatf("d%0d_stall_cin", d), 64'(cin_v[d]), 64'(pc[d]));
                chk($sformatf("d%0d_stall_idx", d), 64'(idx_v[d]), 64'(pi[d]));
            end
            if (valid_v[d] && ready_v[d] && !rst_v[d]) begin
                if (sbq.size() == 0 || sbq[0].dut != d) begin
                    n_tests++; n_fail++;
                    $display("FAIL d%0d_unexpected_xfer: got idx %0d expected no transfer", d, idx_v[d]);
                end else begin
                    e = sbq.pop_front();
                    chk($sformatf("d%0d_idx", d), 64'(idx_v[d]), 64'(e.idx));
                    chk($sformatf("d%0d_a[%0d]", d, e.idx), a_v[d], e.a);
                    chk($sformatf("d%0d_b[%0d]", d, e.idx), b_v[d], e.b);
                    chk($sformatf("d%0d_cin[%0d]", d, e.idx), 64'(cin_v[d]), 64'(e.cin));
                    if (idx_v[d] == 16'd8) first_rand[d] = a_v[d];
                    if (idx_v[d] == 16'd9) second_rand[d] = a_v[d];
                end
            end
            pv[d] = valid_v[d]; pr[d] = ready_v[d]; prst[d] = rst_v[d];
            pa[d] = a_v[d]; pb[d] = b_v[d]; pc[d] = cin_v[d]; pi[d] = idx_v[d];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_done(input int d, input int budget);
        int c;
        c = 0;
        while (!done_v[d] && c < budget) begin
            tick();
            c++;
        end
        chk($sformatf("d%0d_done_reached", d), 64'(done_v[d]), 64'h1);
    endtask

    initial begin
        int c;
        int pat [6];
        logic [64:0] s;

        pat = '{1, 0, 0, 1, 0, 1};
        dtab[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        dtab[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1};
        dtab[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1};
        dtab[3] = '{64'h12, 64'h11, 1'b1, 64'h24, 1'b0};
        dtab[4] = '{64'h12, 64'h11, 1'b0, 64'h23, 1'b0};
        dtab[5] = '{64'h12_4552, 64'h4_7264, 1'b1, 64'h16_B7B7, 1'b0};
        dtab[6] = '{64'h12_4552, 64'h4_7264, 1'b0, 64'h16_B7B6, 1'b0};
        dtab[7] = '{64'h0, 64'h0, 1'b0, 64'h0, 1'b0};

        for (int d = 0; d < 3; d++) begin
            pv[d] = 0; pr[d] = 0; prst[d] = 1; pa[d] = '0; pb[d] = '0; pc[d] = 0; pi[d] = '0;
            first_rand[d] = '0; second_rand[d] = '0;
        end
        rst_v = '1; start_v = '0; ready_v = '0;

        // Reset for two cycles, then idle five cycles.
        tick(); tick();
        rst_v = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("d%0d_idle_ctrl", d),
                    64'({valid_v[d], busy_v[d], done_v[d], cin_v[d], idx_v[d]}), 64'h0);
                chk($sformatf("d%0d_idle_a", d), a_v[d], 64'h0);
                chk($sformatf("d%0d_idle_b", d), b_v[d], 64'h0);
            end
        end

        // Directed set, ready high, N_RANDOM=0.
        ready_v[0] = 1'b1;
        push_seq(0, 0, SEED_DEF);
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        chk("d0_start_valid", 64'(valid_v[0]), 64'h1);
        chk("d0_start_busy", 64'(busy_v[0]), 64'h1);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("d0_vec_idx[%0d]", k), 64'(idx_v[0]), 64'(k));
            s = {1'b0, a_v[0]} + {1'b0, b_v[0]} + 65'(cin_v[0]);
            chk($sformatf("d0_sum[%0d]", k), s[63:0], dtab[k].sum);
            chk($sformatf("d0_cout[%0d]", k), 64'(s[64]), 64'(dtab[k].cout));
            tick();
        end
        chk("d0_done_after_v7", 64'(done_v[0]), 64'h1);
        chk("d0_valid_after_v7", 64'(valid_v[0]), 64'h0);
        chk("d0_busy_after_v7", 64'(busy_v[0]), 64'h0);
        chk("d0_sb_empty", 64'(sbq.size()), 64'h0);

        // Backpressure with N_RANDOM=4.
        push_seq(1, 4, SEED_DEF);
        start_v[1] = 1'b1;
        c = 0;
        while (!done_v[1] && c < 200) begin
            ready_v[1] = pat[c % 6][0];
            tick();
            start_v[1] = 1'b0;
            c++;
        end
        chk("d1_bp_done", 64'(done_v[1]), 64'h1);
        chk("d1_bp_sb_empty", 64'(sbq.size()), 64'h0);
        chk("d1_first_rand_a", first_rand[1], SEED_DEF);
        chk("d1_second_rand_a", second_rand[1], SEED_STEP1);
        chk("d1_done_idx", 64'(idx_v[1]), 64'd12);

        // Second start from DONE replays the same sequence; a start pulse at
        // vec_idx 3 is ignored.
        first_rand[1] = '0; second_rand[1] = '0;
        ready_v[1] = 1'b1;
        push_seq(1, 4, SEED_DEF);
        start_v[1] = 1'b1;
        tick();
        start_v[1] = 1'b0;
        chk("d1_restart_idx", 64'(idx_v[1]), 64'h0);
        chk("d1_restart_done", 64'(done_v[1]), 64'h0);
        c = 0;
        while (!done_v[1] && c < 50) begin
            start_v[1] = (idx_v[1] == 16'd3);
            tick();
            c++;
        end
        start_v[1] = 1'b0;
        chk("d1_replay_done", 64'(done_v[1]), 64'h1);
        chk("d1_replay_sb_empty", 64'(sbq.size()), 64'h0);
        chk("d1_replay_first_rand", first_rand[1], SEED_DEF);

        // Mid-sequence reset at vec_idx 10, with ready still high.
        push_seq(1, 4, SEED_DEF);
        start_v[1] = 1'b1;
        tick();
        start_v[1] = 1'b0;
        c = 0;
        while (idx_v[1] != 16'd10 && c < 50) begin
            tick();
            c++;
        end
        chk("d1_reached_idx10", 64'(idx_v[1]), 64'd10);
        rst_v[1] = 1'b1;
        tick();
        rst_v[1] = 1'b0;
        chk("d1_rst_valid", 64'(valid_v[1]), 64'h0);
        chk("d1_rst_idx", 64'(idx_v[1]), 64'h0);
        chk("d1_rst_busy_done", 64'({busy_v[1], done_v[1]}), 64'h0);
        chk("d1_rst_a", a_v[1], 64'h0);
        chk("d1_rst_leftover", 64'(sbq.size()), 64'd2);
        sbq.delete();
        tick();
        chk("d1_rst_still_idle", 64'({valid_v[1], busy_v[1]}), 64'h0);
        push_seq(1, 4, SEED_DEF);
        start_v[1] = 1'b1;
        tick();
        start_v[1] = 1'b0;
        chk("d1_after_rst_idx", 64'(idx_v[1]), 64'h0);
        chk("d1_after_rst_valid", 64'(valid_v[1]), 64'h1);
        run_until_done(1, 50);
        chk("d1_after_rst_sb_empty", 64'(sbq.size()), 64'h0);

        // Zero seed instance.
        ready_v[2] = 1'b1;
        push_seq(2, 2, 64'h0);
        start_v[2] = 1'b1;
        tick();
        start_v[2] = 1'b0;
        run_until_done(2, 50);
        chk("d2_zero_seed_first_a", first_rand[2], 64'h1);
        chk("d2_sb_empty", 64'(sbq.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
